// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART byte receiver and transmitter.
//   BAUD_*    : baud_set encodings (codes 5..7 fall back to 9600)
//   DIV_W     : width of the baud divisor
//   uart_st_e : frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   bps_div() : 16x-oversampling divisor, round(clk_freq / (baud * 16))
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int DIV_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_st_e;

  // Intended for elaboration-time use only (constant arguments): it divides.
  function automatic logic [DIV_W-1:0] bps_div(input int unsigned clk_freq,
                                               input logic [2:0]  baud_set);
    int unsigned baud;
    case (baud_set)
      BAUD_19200:  baud = 19200;
      BAUD_38400:  baud = 38400;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      default:     baud = 9600;
    endcase
    return DIV_W'((clk_freq + baud * 8) / (baud * 16));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick -- divisor counter producing the 16x oversampling tick.
//   clk_i  : system clock
//   rst_ni : synchronous active-low reset
//   en_i   : count enable
//   clr_i  : force counter to 0 (wins over en_i, suppresses tick)
//   div_i  : divisor; counter runs 0..div_i-1
//   tick_o : one-cycle pulse on the cycle the counter wraps
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = (cnt_q == div_i - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = en_i & ~clr_i & wrap;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx -- 8N1 UART byte receiver, 16x oversampling, 5-sample majority
// vote per bit, baud rate selected by baud_set and latched at start detect.
//   Clk        : system clock
//   Rst_n      : synchronous active-low reset
//   Rs232_Rx   : asynchronous serial line, idle high
//   baud_set   : 0:9600 1:19200 2:38400 3:57600 4:115200, 5-7 -> 9600
//   data_byte  : last good byte, held until the next good frame
//   Rx_Done    : 1-cycle pulse, data_byte updated, frame good
//   Frame_Err  : 1-cycle pulse, stop bit sampled low
//   Parity_Err : 1-cycle pulse, parity mismatch (constant 0 without parity)
//   uart_state : high from start detect until the frame returns to IDLE
// Build option: define UART_RX_PARITY_EN to add a parity bit between data and
// stop (sense set by PARITY_ODD); otherwise the receiver is strictly 8N1.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Rs232_Rx,
  input  logic [2:0] baud_set,
  output logic [7:0] data_byte,
  output logic       Rx_Done,
  output logic       Frame_Err,
  output logic       Parity_Err,
  output logic       uart_state
);

  localparam logic [2:0] IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] START  = 3'(ST_START);
  localparam logic [2:0] DATA   = 3'(ST_DATA);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'(ST_PARITY);
`endif
  localparam logic [2:0] STOP   = 3'(ST_STOP);

  // Divisor table folded to constants so no runtime divider is built.
  localparam logic [DIV_W-1:0] DIV_T0 = bps_div(CLK_FREQ, BAUD_9600);
  localparam logic [DIV_W-1:0] DIV_T1 = bps_div(CLK_FREQ, BAUD_19200);
  localparam logic [DIV_W-1:0] DIV_T2 = bps_div(CLK_FREQ, BAUD_38400);
  localparam logic [DIV_W-1:0] DIV_T3 = bps_div(CLK_FREQ, BAUD_57600);
  localparam logic [DIV_W-1:0] DIV_T4 = bps_div(CLK_FREQ, BAUD_115200);

  // Input synchroniser (s1, s2) plus the previous-sample flop for edge detect.
  logic s1_q, s2_q, s3_q;
  logic fall;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, div_sel;
  logic [3:0]       sub_q, sub_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       ones_q, ones_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             par_bad;
`else
  logic             unused_par_odd;
  assign unused_par_odd = PARITY_ODD;
`endif

  logic       idle, tick, in_win, samp_last, bit_end, vote;
  logic [2:0] ones_sum;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= Rs232_Rx;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign fall = s3_q & ~s2_q;
  assign idle = (state_q == IDLE);

  // Counter is held clear while idle so the first tick of a frame comes a
  // full divisor period after the start edge.
  uart_baud_tick u_tick (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .en_i   (~idle),
    .clr_i  (idle),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    case (baud_set)
      BAUD_19200:  div_sel = DIV_T1;
      BAUD_38400:  div_sel = DIV_T2;
      BAUD_57600:  div_sel = DIV_T3;
      BAUD_115200: div_sel = DIV_T4;
      default:     div_sel = DIV_T0;
    endcase
  end

  // Majority over sub-ticks 6..10: ones_q holds samples 6..9, the current
  // sample completes the vote on the sub-tick-10 tick.
  assign in_win    = (sub_q >= 4'd6) && (sub_q <= 4'd10);
  assign samp_last = tick && (sub_q == 4'd10);
  assign bit_end   = tick && (sub_q == 4'd15);
  assign ones_sum  = ones_q + {2'b00, s2_q};
  assign vote      = (ones_sum >= 3'd3);

`ifdef UART_RX_PARITY_EN
  assign par_bad = (par_q != ((^shreg_q) ^ PARITY_ODD));
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sub_d   = sub_q;
    bit_d   = bit_q;
    ones_d  = ones_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif

    if (tick) begin
      sub_d = sub_q + 4'd1;
      if (in_win) ones_d = (sub_q == 4'd6) ? {2'b00, s2_q} : ones_sum;
    end

    case (state_q)
      IDLE: begin
        sub_d  = '0;
        bit_d  = '0;
        ones_d = '0;
        if (fall) begin
          state_d = START;
          div_d   = div_sel;
        end
      end
      START: begin
        if (samp_last && vote) state_d = IDLE;  // false start / glitch
        else if (bit_end)      state_d = DATA;
      end
      DATA: begin
        if (samp_last) shreg_d = {vote, shreg_q[7:1]};
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (samp_last) par_d = vote;
        if (bit_end)   state_d = STOP;
      end
`endif
      STOP: begin
        // Decide mid stop bit so a start edge right after it is not missed.
        if (samp_last) begin
          state_d = IDLE;
          if (!vote) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_bad) perr_d = 1'b1;
`endif
          else begin
            done_d = 1'b1;
            data_d = shreg_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      sub_q   <= '0;
      bit_q   <= '0;
      ones_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      ones_q  <= ones_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign data_byte  = data_q;
  assign Rx_Done    = done_q;
  assign Frame_Err  = ferr_q;
  assign Parity_Err = perr_q;
  assign uart_state = ~idle;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx -- directed bench for uart_byte_rx. Runs with a 3.6864 MHz
// clock parameter so the divisors are 24/12/6/4/2 and frames stay short.
module tb_uart_byte_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 3_686_400;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Rs232_Rx = 1'b1;
  logic [2:0] baud_set = 3'd0;
  logic [7:0] data_byte;
  logic       Rx_Done, Frame_Err, Parity_Err, uart_state;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .PARITY_ODD(1'b0)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Rs232_Rx   (Rs232_Rx),
    .baud_set   (baud_set),
    .data_byte  (data_byte),
    .Rx_Done    (Rx_Done),
    .Frame_Err  (Frame_Err),
    .Parity_Err (Parity_Err),
    .uart_state (uart_state)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int         rx_cnt = 0, ferr_cnt = 0, perr_cnt = 0, multi = 0;
  int         run = 0, last_run = 0;
  logic [7:0] rx_q[$];

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (Rx_Done) begin rx_cnt++; rx_q.push_back(data_byte); end
      if (Frame_Err)  ferr_cnt++;
      if (Parity_Err) perr_cnt++;
      if ((int'(Rx_Done) + int'(Frame_Err) + int'(Parity_Err)) > 1) multi++;
      if (uart_state) run++;
      else if (run != 0) begin last_run = run; run = 0; end
    end else begin
      run = 0;
    end
  end

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    check(tag, {24'h0, got}, {24'h0, exp});
  endtask

  // Drive the line to v for n clock cycles (starts/ends 1 ns after posedge).
  task automatic hold(input logic v, input int n);
    Rs232_Rx = v;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Edge offsets in sub-ticks for jittered frames; 0 at frame start and end.
  int jt[0:11] = '{0, 2, -2, 1, -1, 2, -2, 0, 2, -1, 1, 0};

  // jit: 0 none, +1/-1 applies jt[] (or its negation) to every inner edge.
  // alt_bs >= 0: baud_set is changed to it while bit 0 is on the line.
  task automatic send_frame(input logic [7:0] d, input int div, input bit bad_par,
                            input logic stop, input int jit, input int alt_bs);
    logic b[0:10];
    int   ncell, bp, o0, o1;
    bp   = 16 * div;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
    ncell = 11;
    b[9]  = (^d) ^ bad_par;
`else
    ncell = 10;
    if (bad_par) ncell = 10;
`endif
    b[ncell-1] = stop;
    for (int c = 0; c < ncell; c++) begin
      if (c == 1 && alt_bs >= 0) baud_set = 3'(alt_bs);
      o0 = (c == 0) ? 0 : jt[c] * jit;
      o1 = (c + 1 >= ncell) ? 0 : jt[c+1] * jit;
      hold(b[c], bp + (o1 - o0) * div);
    end
  endtask

  int r0, f0, p0;

  initial begin
    @(posedge Clk); #1;
    hold(1'b1, 4);
    // reset state
    check("rst_data", {24'h0, data_byte}, 32'h0);
    check("rst_done", {31'h0, Rx_Done}, 32'h0);
    check("rst_ferr", {31'h0, Frame_Err}, 32'h0);
    check("rst_perr", {31'h0, Parity_Err}, 32'h0);
    check("rst_state", {31'h0, uart_state}, 32'h0);

    // divisor table at 50 MHz
    check("div_9600",   {16'h0, bps_div(50_000_000, 3'd0)}, 32'd326);
    check("div_19200",  {16'h0, bps_div(50_000_000, 3'd1)}, 32'd163);
    check("div_38400",  {16'h0, bps_div(50_000_000, 3'd2)}, 32'd81);
    check("div_57600",  {16'h0, bps_div(50_000_000, 3'd3)}, 32'd54);
    check("div_115200", {16'h0, bps_div(50_000_000, 3'd4)}, 32'd27);
    check("div_code7",  {16'h0, bps_div(50_000_000, 3'd7)}, 32'd326);

    Rst_n = 1'b1;
    hold(1'b1, 20);

    // 0x55 at 9600, baud_set flipped to 115200 during bit 0 (must be ignored)
    baud_set = 3'd0;
    send_frame(8'h55, 24, 1'b0, 1'b1, 0, 4);
    hold(1'b1, 2 * 384);
    check("b55_cnt", rx_cnt, 32'd1);
    expect_byte("b55_byte", 8'h55);
    check("b55_out", {24'h0, data_byte}, 32'h55);
    // busy for ~9.7 bit-times (start detect to mid stop bit)
    check("b55_busy", {31'h0, (last_run >= 3648) && (last_run <= 3763)}, 32'd1);

    // back-to-back at 115200
    baud_set = 3'd4;
    send_frame(8'hA3, 2, 1'b0, 1'b1, 0, -1);
    send_frame(8'h0F, 2, 1'b0, 1'b1, 0, -1);
    hold(1'b1, 64);
    check("b2b_cnt", rx_cnt, 32'd3);
    expect_byte("b2b_1", 8'hA3);
    expect_byte("b2b_2", 8'h0F);

    // stop bit low: frame error, data_byte held
    send_frame(8'h3C, 2, 1'b0, 1'b0, 0, -1);
    hold(1'b1, 64);
    check("ferr_cnt", ferr_cnt, 32'd1);
    check("ferr_nodone", rx_cnt, 32'd3);
    check("ferr_hold", {24'h0, data_byte}, 32'h0F);

    // break: line low for 30 bit-times -> one frame error only
    hold(1'b0, 30 * 32);
    hold(1'b1, 64);
    check("brk_ferr", ferr_cnt, 32'd2);
    check("brk_nodone", rx_cnt, 32'd3);

    // 2-sub-tick low glitch on idle line
    hold(1'b0, 4);
    check("glitch_seen", {31'h0, uart_state}, 32'd1);
    hold(1'b1, 32);
    check("glitch_idle", {31'h0, uart_state}, 32'd0);
    check("glitch_nopulse", rx_cnt + ferr_cnt + perr_cnt, 32'd5);

    // reset during bit 4 of 0xFF
    hold(1'b0, 32);
    hold(1'b1, 4 * 32 + 16);
    Rst_n = 1'b0;
    hold(1'b1, 3);
    check("mrst_data", {24'h0, data_byte}, 32'h0);
    check("mrst_state", {31'h0, uart_state}, 32'd0);
    check("mrst_pulse", {29'h0, Rx_Done, Frame_Err, Parity_Err}, 32'd0);
    Rst_n = 1'b1;
    hold(1'b1, 4 * 32);
    send_frame(8'h81, 2, 1'b0, 1'b1, 0, -1);
    hold(1'b1, 64);
    check("mrst_cnt", rx_cnt, 32'd4);
    expect_byte("mrst_81", 8'h81);

    // jittered bit cells at 19200
    baud_set = 3'd1;
    send_frame(8'h5A, 12, 1'b0, 1'b1, 1, -1);
    send_frame(8'hC3, 12, 1'b0, 1'b1, -1, -1);
    send_frame(8'h96, 12, 1'b0, 1'b1, 1, -1);
    hold(1'b1, 2 * 192);
    check("jit_cnt", rx_cnt, 32'd7);
    expect_byte("jit_1", 8'h5A);
    expect_byte("jit_2", 8'hC3);
    expect_byte("jit_3", 8'h96);

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 has three ones -> parity bit 1 is good, 0 is bad
    baud_set = 3'd4;
    r0 = rx_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'h07, 2, 1'b0, 1'b1, 0, -1);
    hold(1'b1, 64);
    check("par_ok_cnt", rx_cnt - r0, 32'd1);
    expect_byte("par_ok_byte", 8'h07);
    send_frame(8'h07, 2, 1'b1, 1'b1, 0, -1);
    hold(1'b1, 64);
    check("par_bad_perr", perr_cnt - p0, 32'd1);
    check("par_bad_nodone", rx_cnt - r0, 32'd1);
    send_frame(8'h07, 2, 1'b1, 1'b0, 0, -1);
    hold(1'b1, 64);
    check("par_prio_ferr", ferr_cnt - f0, 32'd1);
    check("par_prio_perr", perr_cnt - p0, 32'd1);
`else
    check("perr_tied", perr_cnt, 32'd0);
`endif

    check("one_pulse", multi, 32'd0);
    check("queue_empty", rx_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
